// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding and default sizes for the run controller
package ctrl_pkg;
    localparam int MODULUS_DEF = 6;
    localparam int PHASE_W_DEF = 3;
    localparam int LEN_W_DEF   = 16;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t PAUSED = 2'd2;
    localparam state_t DONE   = 2'd3;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: mod-N phase counter with synchronous clear over enable
module mod_counter #(
    parameter int MODULUS = 6,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [PHASE_W-1:0] out
);
    logic [PHASE_W-1:0] out_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_q <= '0;
        else if (clear)
            out_q <= '0;
        else if (enable)
            out_q <= (out_q == PHASE_W'(MODULUS - 1)) ? '0 : out_q + PHASE_W'(1);
    end
    assign out = out_q;
endmodule

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: drives the phase counter enable for a run of N cycles
module counter_run_ctrl import ctrl_pkg::*; #(
    parameter int MODULUS = MODULUS_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   run_len,
    input  logic               pause,
    input  logic               stop,
    output logic               count_enable,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic [LEN_W-1:0]   remaining,
    output logic               busy,
    output logic               done
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             idle, active, clear;
    assign idle         = state_q == IDLE;
    assign active       = state_q == RUN || state_q == PAUSED;
    assign count_enable = state_q == RUN && !stop && !pause;
    assign wrap         = count_enable && phase == PHASE_W'(MODULUS - 1);
    assign busy         = active;
    assign done         = state_q == DONE;
    assign remaining    = rem_q;
    assign clear        = (idle && start) || (active && stop);
    // remaining only decrements on enabled cycles, which require rem_q >= 1
    assign rem_d = (idle && start) ? run_len :
                   (active && stop) ? '0 :
                   count_enable ? rem_q - LEN_W'(1) : rem_q;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = !start ? IDLE : (run_len != '0) ? RUN : DONE;
            RUN:     state_d = stop ? IDLE : pause ? PAUSED : (rem_q == LEN_W'(1)) ? DONE : RUN;
            PAUSED:  state_d = stop ? IDLE : pause ? PAUSED : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end
    mod_counter #(.MODULUS(MODULUS), .PHASE_W(PHASE_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (count_enable),
        .out    (phase)
    );
endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed vector bench for the run controller
module tb_counter_run_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, pause, stop;
    logic [15:0] run_len;
    logic        count_enable, wrap, busy, done;
    logic [2:0]  phase;
    logic [15:0] remaining;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        st;
        logic [15:0] rl;
        logic        pa, sp, ce;
        logic [2:0]  ph;
        logic        wr;
        logic [15:0] rem;
        logic        bz, dn;
    } vec_t;
    vec_t tbl[$];

    counter_run_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .run_len(run_len),
        .pause(pause), .stop(stop), .count_enable(count_enable),
        .phase(phase), .wrap(wrap), .remaining(remaining),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int st, int rl, int pa, int sp, int ce, int ph, int wr, int rem, int bz, int dn);
        vec_t v;
        v.st = st[0]; v.rl = 16'(rl); v.pa = pa[0]; v.sp = sp[0]; v.ce = ce[0];
        v.ph = 3'(ph); v.wr = wr[0]; v.rem = 16'(rem); v.bz = bz[0]; v.dn = dn[0];
        return v;
    endfunction

    task automatic add(int st, int rl, int pa, int sp, int ce, int ph, int wr, int rem, int bz, int dn);
        tbl.push_back(mk(st, rl, pa, sp, ce, ph, wr, rem, bz, dn));
    endtask

    task automatic chk(string nm, int idx, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s got=%0d want=%0d", idx, nm, act, exp);
        end
    endtask

    task automatic chk_out(int idx, vec_t v);
        chk("count_enable", idx, 16'(count_enable), 16'(v.ce));
        chk("phase", idx, 16'(phase), 16'(v.ph));
        chk("wrap", idx, 16'(wrap), 16'(v.wr));
        chk("remaining", idx, remaining, v.rem);
        chk("busy", idx, 16'(busy), 16'(v.bz));
        chk("done", idx, 16'(done), 16'(v.dn));
    endtask

    task automatic step(int idx, vec_t v);
        @(negedge clk);
        start = v.st; run_len = v.rl; pause = v.pa; stop = v.sp;
        #1;
        chk_out(idx, v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; run_len = '0; pause = 1'b0; stop = 1'b0;
        // run_len=3 basic run
        add(1,3,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 1,0,0,3,1,0);
        add(0,0,0,0, 1,1,0,2,1,0);
        add(0,0,0,0, 1,2,0,1,1,0);
        add(0,0,0,0, 0,3,0,0,0,1);
        add(0,0,0,0, 0,3,0,0,0,0);
        // run_len=8 wraps once at phase 5
        add(1,8,0,0, 0,3,0,0,0,0);
        for (int i = 0; i < 8; i++) add(0,0,0,0, 1,i%6,(i==5)?1:0,8-i,1,0);
        add(0,0,0,0, 0,2,0,0,0,1);
        add(0,0,0,0, 0,2,0,0,0,0);
        // run_len=5 with a 4-cycle pause after the 2nd enabled cycle
        add(1,5,0,0, 0,2,0,0,0,0);
        add(0,0,0,0, 1,0,0,5,1,0);
        add(0,0,0,0, 1,1,0,4,1,0);
        for (int i = 0; i < 4; i++) add(0,0,1,0, 0,2,0,3,1,0);
        add(0,0,0,0, 0,2,0,3,1,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 1,2+i,0,3-i,1,0);
        add(0,0,0,0, 0,5,0,0,0,1);
        add(0,0,0,0, 0,5,0,0,0,0);
        // run_len=10 aborted after 4 enabled cycles; start while busy ignored
        add(1,10,0,0, 0,5,0,0,0,0);
        add(0,0,0,0, 1,0,0,10,1,0);
        add(1,3,0,0, 1,1,0,9,1,0);
        add(0,0,0,0, 1,2,0,8,1,0);
        add(0,0,0,0, 1,3,0,7,1,0);
        add(0,0,0,1, 0,4,0,6,1,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        // stop while paused
        add(1,4,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 1,0,0,4,1,0);
        add(0,0,1,0, 0,1,0,3,1,0);
        add(0,0,1,1, 0,1,0,3,1,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        // run_len=0 gives a bare done pulse; start in DONE ignored
        add(1,0,0,0, 0,0,0,0,0,0);
        add(1,5,0,0, 0,0,0,0,0,1);
        add(0,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);

        #3;
        chk_out(-1, mk(0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) step(i, tbl[i]);

        // asynchronous reset mid-run at phase=4 remaining=7
        step(100, mk(1,11,0,0, 0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) step(101+i, mk(0,0,0,0, 1,i,0,11-i,1,0));
        #1 reset = 1'b1;
        #1 chk_out(110, mk(0,0,0,0, 0,0,0,0,0,0));
        @(posedge clk);
        #1 chk_out(111, mk(0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;
        step(120, mk(1,2,0,0, 0,0,0,0,0,0));
        step(121, mk(0,0,0,0, 1,0,0,2,1,0));
        step(122, mk(0,0,0,0, 1,1,0,1,1,0));
        step(123, mk(0,0,0,0, 0,2,0,0,0,1));
        step(124, mk(0,0,0,0, 0,2,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
